// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and oversampling constants.
// No ports; imported by the UART receive path.
package uart_pkg;

   // Ticks of the baud generator per bit period.
   localparam int unsigned OVERSAMPLE = 16;
   // Tick count at which the start bit is checked (mid-bit).
   localparam int unsigned MID_BIT    = 7;

   // Receiver FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high reset; both flops load ResetVal
//   d     - asynchronous input
//   q     - synchronized output, 2 clk latency
module sync_2ff #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= ResetVal;
         q      <= ResetVal;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampling UART receiver. Recovers one frame (start, DBIT data bits LSB-first,
// optional parity, stop) at a time and reports it with a single-cycle rx_done_tick.
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   rx           - raw serial line, asynchronous, idle high
//   s_tick       - one-cycle pulse at 16x the baud rate
//   rx_done_tick - one-cycle pulse: frame complete, dout/flags valid
//   dout         - received data right-aligned in [DBIT-1:0], upper bits 0
//   frame_err    - stop bit sampled low on the last frame
//   parity_err   - parity mismatch on the last frame (0 when parity is disabled)
//   busy         - high whenever the FSM is not idle
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DBIT       = 8,
   parameter int unsigned SB_TICK    = 16,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       s_tick,
   output logic       rx_done_tick,
   output logic [7:0] dout,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam logic [4:0]  MID_TICK   = 5'(MID_BIT);
   localparam logic [4:0]  LAST_TICK  = 5'(OVERSAMPLE - 1);
   // Tick counter is 5 bits so 1.5 and 2 stop bits (24/32 ticks) fit.
   localparam logic [4:0]  STOP_LAST  = 5'(SB_TICK - 1);
   localparam logic [2:0]  DATA_LAST  = 3'(DBIT - 1);
   localparam int unsigned DOUT_SHIFT = 8 - DBIT;
   localparam logic        PAR_ODD    = (PARITY_ODD != 0);

   rx_state_e  state_q, state_d;
   logic [4:0] s_q, s_d;
   logic [2:0] n_q, n_d;
   logic [7:0] b_q, b_d;
   logic       p_q, p_d;
   logic       perr_q, perr_d;
   logic [7:0] dout_d;
   logic       frame_err_d, parity_err_d, done_d;
   logic       rx_s;

   sync_2ff #(
      .ResetVal(1'b1)
   ) u_rx_sync (
      .clk  (clk),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      p_d          = p_q;
      perr_d       = perr_q;
      dout_d       = dout;
      frame_err_d  = frame_err;
      parity_err_d = parity_err;
      done_d       = 1'b0;

      case (state_q)
         StIdle: begin
            // Falling edge starts a frame without waiting for a tick.
            if (!rx_s) begin
               state_d = StStart;
               s_d     = '0;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (s_q == MID_TICK) begin
                  s_d = '0;
                  if (!rx_s) begin
                     state_d = StData;
                     n_d     = '0;
                     p_d     = 1'b0;
                     perr_d  = 1'b0;
                  end else begin
                     // Glitch: outputs untouched.
                     state_d = StIdle;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (s_q == LAST_TICK) begin
                  b_d = {rx_s, b_q[7:1]};
                  p_d = p_q ^ rx_s;
                  s_d = '0;
                  if (n_q == DATA_LAST) begin
                     state_d = (PARITY_EN != 0) ? StParity : StStop;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StParity: begin
            if (s_tick) begin
               if (s_q == LAST_TICK) begin
                  perr_d  = p_q ^ rx_s ^ PAR_ODD;
                  s_d     = '0;
                  state_d = StStop;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StStop: begin
            if (s_tick) begin
               if (s_q == STOP_LAST) begin
                  state_d      = StIdle;
                  s_d          = '0;
                  // Data was shifted in from the top; align it to bit 0.
                  dout_d       = b_q >> DOUT_SHIFT;
                  frame_err_d  = ~rx_s;
                  parity_err_d = perr_q;
                  done_d       = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            s_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         p_q          <= 1'b0;
         perr_q       <= 1'b0;
         dout         <= '0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         p_q          <= p_d;
         perr_q       <= perr_d;
         dout         <= dout_d;
         frame_err    <= frame_err_d;
         parity_err   <= parity_err_d;
         rx_done_tick <= done_d;
      end
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame. Four instances share clk/reset/s_tick:
//   0: 8N1, 1: 8E1, 2: 8O1, 3: 7 data bits with 2 stop bits.
// Directed frames push hand-computed results into a scoreboard; a monitor pops
// and compares on every rx_done_tick.
module tb_uart_rx_frame;

   localparam int TP = 4;   // clk cycles per s_tick

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] dout;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       rx_l    [4];
   logic       done_w  [4];
   logic [7:0] dout_w  [4];
   logic       fe_w    [4];
   logic       pe_w    [4];
   logic       busy_w  [4];

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] last_dout [4];
   logic       last_fe   [4];
   logic       last_pe   [4];

   always #5 clk = ~clk;

   uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
      .clk(clk), .reset(reset), .rx(rx_l[0]), .s_tick(s_tick), .rx_done_tick(done_w[0]),
      .dout(dout_w[0]), .frame_err(fe_w[0]), .parity_err(pe_w[0]), .busy(busy_w[0]));

   uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
      .clk(clk), .reset(reset), .rx(rx_l[1]), .s_tick(s_tick), .rx_done_tick(done_w[1]),
      .dout(dout_w[1]), .frame_err(fe_w[1]), .parity_err(pe_w[1]), .busy(busy_w[1]));

   uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
      .clk(clk), .reset(reset), .rx(rx_l[2]), .s_tick(s_tick), .rx_done_tick(done_w[2]),
      .dout(dout_w[2]), .frame_err(fe_w[2]), .parity_err(pe_w[2]), .busy(busy_w[2]));

   uart_rx_frame #(.DBIT(7), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_7n2 (
      .clk(clk), .reset(reset), .rx(rx_l[3]), .s_tick(s_tick), .rx_done_tick(done_w[3]),
      .dout(dout_w[3]), .frame_err(fe_w[3]), .parity_err(pe_w[3]), .busy(busy_w[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Baud tick: one cycle high every TP cycles.
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (TP - 1) @(posedge clk);
         #1 s_tick = 1'b1;
         @(posedge clk);
         #1 s_tick = 1'b0;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (done_w[k] === 1'b1) begin
            exp_t e;
            check($sformatf("pulse_expected dut%0d", k), 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check($sformatf("dut_index dut%0d", k), 32'(k), 32'(e.idx));
               check($sformatf("dout dut%0d", k), 32'(dout_w[k]), 32'(e.dout));
               check($sformatf("frame_err dut%0d", k), 32'(fe_w[k]), 32'(e.fe));
               check($sformatf("parity_err dut%0d", k), 32'(pe_w[k]), 32'(e.pe));
               check($sformatf("busy_at_done dut%0d", k), 32'(busy_w[k]), 32'd0);
            end
         end
      end
   end

   task automatic hold(input int k, input logic v, input int ticks);
      rx_l[k] = v;
      repeat (ticks * TP) @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] data, input int nbits, input bit has_par,
                       input logic par_bit, input int stop_ticks, input logic stop_val,
                       input int idle_ticks, input logic [7:0] e_dout, input logic e_fe,
                       input logic e_pe);
      sb.push_back('{idx: 2'(k), dout: e_dout, fe: e_fe, pe: e_pe});
      last_dout[k] = e_dout;
      last_fe[k]   = e_fe;
      last_pe[k]   = e_pe;
      hold(k, 1'b0, 16);
      for (int i = 0; i < nbits; i++) hold(k, data[i], 16);
      if (has_par) hold(k, par_bit, 16);
      hold(k, stop_val, stop_ticks);
      if (idle_ticks > 0) hold(k, 1'b1, idle_ticks);
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      while (sb.size() != 0 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         rx_l[k]      = 1'b1;
         last_dout[k] = 8'h00;
         last_fe[k]   = 1'b0;
         last_pe[k]   = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset done",  32'(done_w[0]), 32'd0);
      check("reset dout",  32'(dout_w[0]), 32'd0);
      check("reset fe",    32'(fe_w[0]),   32'd0);
      check("reset pe",    32'(pe_w[0]),   32'd0);
      check("reset busy",  32'(busy_w[0]), 32'd0);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // 8N1 basic frame.
      send(0, 8'h55, 8, 0, 1'b0, 16, 1'b1, 32, 8'h55, 1'b0, 1'b0);
      drain("drain 0x55");
      check("busy after 0x55", 32'(busy_w[0]), 32'd0);

      // Start glitch: low for 4 ticks only.
      hold(0, 1'b0, 4);
      hold(0, 1'b1, 48);
      check("glitch no pulse", 32'(sb.size()), 32'd0);
      check("glitch dout",     32'(dout_w[0]), 32'(last_dout[0]));
      check("glitch fe",       32'(fe_w[0]),   32'(last_fe[0]));
      check("glitch busy",     32'(busy_w[0]), 32'd0);

      // Stop bit low (short so the line is high again before a false start is checked).
      send(0, 8'hA3, 8, 0, 1'b0, 12, 1'b0, 48, 8'hA3, 1'b1, 1'b0);
      drain("drain 0xA3");
      send(0, 8'h3C, 8, 0, 1'b0, 16, 1'b1, 32, 8'h3C, 1'b0, 1'b0);
      drain("drain 0x3C");

      // Parity: 0x07 has three ones.
      send(1, 8'h07, 8, 1, 1'b1, 16, 1'b1, 32, 8'h07, 1'b0, 1'b0);
      send(1, 8'h07, 8, 1, 1'b0, 16, 1'b1, 32, 8'h07, 1'b0, 1'b1);
      send(2, 8'h07, 8, 1, 1'b0, 16, 1'b1, 32, 8'h07, 1'b0, 1'b0);
      drain("drain parity");

      // Reset during data bit 3 of 0xFF.
      hold(0, 1'b0, 16);
      hold(0, 1'b1, 16 * 3 + 8);
      check("busy mid frame", 32'(busy_w[0]), 32'd1);
      reset = 1'b1;
      #1;
      check("async reset done", 32'(done_w[0]), 32'd0);
      check("async reset dout", 32'(dout_w[0]), 32'd0);
      check("async reset fe",   32'(fe_w[0]),   32'd0);
      check("async reset pe",   32'(pe_w[1]),   32'd0);
      check("async reset busy", 32'(busy_w[0]), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         last_dout[k] = 8'h00;
         last_fe[k]   = 1'b0;
         last_pe[k]   = 1'b0;
      end
      hold(0, 1'b1, 16 * 5 + 48);
      check("post reset idle", 32'(busy_w[0]), 32'd0);
      send(0, 8'hC4, 8, 0, 1'b0, 16, 1'b1, 32, 8'hC4, 1'b0, 1'b0);
      drain("drain 0xC4");

      // Back-to-back frames with no idle gap.
      send(0, 8'h00, 8, 0, 1'b0, 16, 1'b1, 0,  8'h00, 1'b0, 1'b0);
      send(0, 8'hFF, 8, 0, 1'b0, 16, 1'b1, 32, 8'hFF, 1'b0, 1'b0);
      drain("drain back-to-back");

      // 7 data bits, 2 stop bits.
      send(3, 8'h5A, 7, 0, 1'b0, 32, 1'b1, 32, 8'h5A, 1'b0, 1'b0);
      drain("drain 7N2");
      check("busy after 7N2", 32'(busy_w[3]), 32'd0);

      repeat (20) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
